// File: rtl/ebr_sp_arbiter.sv
// ebr_sp_arbiter: round-robin two-requester controller for a single-port EBR,
// with registered RAM lines, read-return pipeline and a zero-fill clear sweep.
module ebr_sp_arbiter #(
  parameter int READ_LAT     = 1,
  parameter int DEPTH        = 512,
  parameter bit CLR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [12:0] ad0_in,
  input  logic [12:0] ad1_in,
  input  logic [17:0] di0_in,
  input  logic [17:0] di1_in,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [17:0] rdata,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [12:0] ram_ad,
  output logic [17:0] ram_di,
  input  logic [17:0] ram_do
);
  typedef enum logic [1:0] {IDLE, ARB, CLEAR, DONE} state_t;
  state_t state, state_nx;
  logic ptr;
  logic [12:0] cnt;
  logic [READ_LAT:0] pv, pid;
  logic arb, sweep_end, rd_push;
  assign arb       = state == ARB && !clr_start;
  assign gnt0      = arb && req0 && (!req1 || !ptr);
  assign gnt1      = arb && req1 && (!req0 || ptr);
  assign sweep_end = cnt == 13'(DEPTH - 1);
  assign rd_push   = (gnt0 && !we0) || (gnt1 && !we1);
  assign rvalid0   = pv[READ_LAT] && !pid[READ_LAT];
  assign rvalid1   = pv[READ_LAT] && pid[READ_LAT];
  assign rdata     = ram_do;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE  ? ((CLR_ON_RESET || clr_start) ? CLEAR : ARB) :
               state == ARB   ? (clr_start ? CLEAR : ARB) :
               state == CLEAR ? (sweep_end ? DONE : CLEAR) : ARB;
  end
  always_comb begin
    clr_busy = state == CLEAR;
    clr_done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_ce <= 1'b0;
      ram_we <= 1'b0;
      ram_ad <= '0;
      ram_di <= '0;
      cnt    <= '0;
      ptr    <= 1'b0;
      pv     <= '0;
      pid    <= '0;
    end else begin
      ram_ce <= gnt0 || gnt1 || clr_busy;
      ram_we <= clr_busy || (gnt0 && we0) || (gnt1 && we1);
      if (clr_busy) begin
        ram_ad <= cnt;
        ram_di <= '0;
      end else if (gnt0) begin
        ram_ad <= ad0_in;
        ram_di <= di0_in;
      end else if (gnt1) begin
        ram_ad <= ad1_in;
        ram_di <= di1_in;
      end
      cnt <= (clr_busy && !sweep_end) ? cnt + 13'd1 : '0;
      // only a contested grant hands priority to the loser
      if (req0 && req1 && (gnt0 || gnt1)) ptr <= gnt0;
      pv  <= {pv[READ_LAT-1:0], rd_push};
      pid <= {pid[READ_LAT-1:0], gnt1};
    end
  end
endmodule

// File: doc/ebr_sp_arbiter.md
Name: ebr_sp_arbiter

Overview:
- Two-requester controller for one single-port 9-kbit EBR wrapper, 18-bit data, 13-bit address.
- Grants the RAM each cycle to one requester using round-robin arbitration and registers the RAM control, address and data lines.
- Tracks read latency for the wrapper's REGMODE and returns read data to the requester that issued it.
- Includes a clear sequencer that writes zero to every word after power-up or on command.

Parameters:
- READ_LAT, 1, EBR read latency in clocks after the RAM's sampling edge: 1 for "NOREG", 2 for "OUTREG".
- DEPTH, 512, number of words swept by the clear sequencer. Legal range 1..8192.
- CLR_ON_RESET, 1, when 1 the clear sweep starts automatically after reset deasserts.

Ports:
- CLK  input  1  single clock for the controller and the EBR.
- RST  input  1  asynchronous, active-low reset.
- REQ0, REQ1  input  1  access request from requester 0 / 1.
- WE0, WE1  input  1  1 = write, 0 = read. Qualified by REQn.
- AD0_IN, AD1_IN  input  13  request address.
- DI0_IN, DI1_IN  input  18  write data.
- GNT0, GNT1  output  1  combinational grant, asserted in the cycle the request is accepted.
- RVALID0, RVALID1  output  1  one-cycle pulse; read data for that requester is on RDATA.
- RDATA  output  18  read data, driven straight from RAM_DO.
- CLR_START  input  1  pulse that starts a clear sweep.
- CLR_BUSY  output  1  high while the sweep runs.
- CLR_DONE  output  1  one-cycle pulse when the sweep completes.
- RAM_CE, RAM_WE  output  1  registered EBR clock enable / write enable.
- RAM_AD  output  13  registered EBR address.
- RAM_DI  output  18  registered EBR write data.
- RAM_DO  input  18  EBR data output.

Behaviour:
- Reset values: every output and all internal state is 0, priority pointer = requester 0, FSM = IDLE.
  - With CLR_ON_RESET = 1, the FSM enters CLEAR on the first clock after RST deasserts.
- FSM states: IDLE, ARB, CLEAR, DONE.
  - IDLE -> ARB when no clear is pending.
  - ARB -> CLEAR on CLR_START. CLR_START wins over any pending REQ in that cycle, and no grant is issued.
  - CLEAR -> DONE after the write to address DEPTH-1.
  - DONE lasts 1 cycle, pulses CLR_DONE, then moves to ARB.
- Arbitration (ARB only):
  - If only one REQ is high, that requester is granted.
  - If both are high, the requester named by the pointer is granted, and the pointer then moves to the other requester.
  - A single request does not move the pointer.
  - At most one GNT is high per cycle. GNT is never asserted outside ARB.
- Handshake:
  - A requester holds REQ, WE, AD and DI stable until it samples GNT high; the request is accepted on that edge.
  - Back-to-back grants to the same requester are allowed in consecutive cycles.
- Issue timing, with the grant in cycle t:
  - At the edge ending cycle t, the controller registers RAM_CE=1, RAM_WE=WEn, RAM_AD=ADn_IN, RAM_DI=DIn_IN.
  - The EBR samples these at the edge ending cycle t+1.
  - In any cycle with no grant and no clear write, RAM_CE is registered to 0 and RAM_WE to 0.
- Read return:
  - Each granted read pushes a valid bit and a requester ID into a shift pipeline of depth READ_LAT+1.
  - RVALIDn is asserted in cycle t+1+READ_LAT, with RDATA = RAM_DO.
  - Writes produce no RVALID.
  - Reads already in the pipeline always complete, even if a clear starts after them.
- CLEAR sequence:
  - A 13-bit counter runs from 0 to DEPTH-1, one write per cycle: RAM_CE=1, RAM_WE=1, RAM_AD=counter, RAM_DI=0.
  - CLR_BUSY is high for exactly DEPTH cycles.
  - CLR_START during CLEAR or DONE is ignored.
  - REQs during CLEAR or DONE stay pending, with no GNT.
- Boundaries:
  - DEPTH=1 gives a one-cycle sweep.
  - The counter does not wrap; the sweep stops at DEPTH-1.
  - RST asserted mid-sweep aborts immediately: outputs return to reset values and no CLR_DONE is issued.
  - With CLR_ON_RESET = 1 the sweep restarts after reset; with 0 it does not.
  - RST asserted with reads in flight discards them, and no RVALID is issued.

Test Plan:
- Reset-time clear: CLR_ON_RESET=1, DEPTH=512 -> CLR_BUSY high 512 cycles, RAM_AD steps 0..511 with RAM_DI=0, CLR_DONE pulses once, a later read of address 0x1FF returns 0.
- Round-robin: REQ0 and REQ1 held high for 6 cycles, all writes -> grants alternate 0,1,0,1,0,1 starting with 0 after reset. Read-back returns 0x3FFFF at address 5 (written by requester 0) and 0x00001 at address 6 (written by requester 1).
- Read latency, READ_LAT=1: requester 1 reads address 0x0A0 (holding 0x2AAAA), granted in cycle t -> RVALID1 in cycle t+2 with RDATA=0x2AAAA. With READ_LAT=2, RVALID1 moves to t+3.
- Back-to-back reads: requester 0 alone reads addresses 1,2,3 in consecutive cycles -> RVALID0 on 3 consecutive cycles, returning the matching data in order.
- Clear vs. request: CLR_START and REQ0 high in the same cycle -> no GNT0. GNT0 is first asserted the cycle after CLR_DONE, and a read already in flight completes normally.
- Reset mid-sweep: RST low at counter = 100 -> all outputs 0 asynchronously, no CLR_DONE. After release, the sweep restarts from address 0.
